// File: rtl/axi4_burst_master.sv
// axi4_burst_master: issues single INCR bursts (full-width beats, all byte
// lanes enabled) on an AXI4 master port on behalf of a simple command port.
//
// Ports:
//   ACLK, ARESETn            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake (ready only while idle)
//   cmd_write/addr/len       burst direction, start address, beats-1
//   wdata_req/wdata_in       per-beat write data pull (data sampled while req=1)
//   rdata_valid/rdata_out    per-beat read data push
//   done/done_resp           burst-complete pulse with BRESP / worst RRESP
//   AW*, W*, B*, AR*, R*     AXI4 master channels
//
// Build option: define AXI4_MASTER_TIMEOUT_EN to add a response watchdog that
// ends a burst with done_resp=2'b11 after 16 idle cycles in WRESP or RDATA.
module axi4_burst_master #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              wdata_req,
  output logic [DATA_W-1:0] rdata_out,
  output logic              rdata_valid,
  output logic              done,
  output logic [1:0]        done_resp,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [7:0]        AWLEN,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY
);

  localparam int unsigned LEN_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WDATA,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_q, beat_d;

  logic               cmd_ready_d, wdata_req_d, rdata_valid_d, done_d;
  logic [DATA_W-1:0]  rdata_out_d, wdata_d;
  logic [1:0]         done_resp_d;
  logic [ADDR_W-1:0]  awaddr_d, araddr_d;
  logic [LEN_W-1:0]   awlen_d, arlen_d;
  logic               awvalid_d, wlast_d, wvalid_d, bready_d, arvalid_d, rready_d;

`ifdef AXI4_MASTER_TIMEOUT_EN
  localparam int unsigned WD_W = 5;
  logic [WD_W-1:0]    wd_q, wd_d;
`endif

  // Next-state and next-output logic; every registered output has a _d twin.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    beat_d        = beat_q;
    wdata_req_d   = 1'b0;
    rdata_valid_d = 1'b0;
    done_d        = 1'b0;
    rdata_out_d   = rdata_out;
    done_resp_d   = done_resp;
    awaddr_d      = AWADDR;
    awlen_d       = AWLEN;
    awvalid_d     = AWVALID;
    wdata_d       = WDATA;
    wlast_d       = WLAST;
    wvalid_d      = WVALID;
    bready_d      = BREADY;
    araddr_d      = ARADDR;
    arlen_d       = ARLEN;
    arvalid_d     = ARVALID;
    rready_d      = RREADY;
`ifdef AXI4_MASTER_TIMEOUT_EN
    // Cleared on every handshake and outside the two waiting states.
    wd_d          = '0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          len_d       = cmd_len;
          beat_d      = '0;
          done_resp_d = '0;
          if (cmd_write) begin
            state_d   = S_WADDR;
            awaddr_d  = cmd_addr;
            awlen_d   = cmd_len;
            awvalid_d = 1'b1;
          end else begin
            state_d   = S_RADDR;
            araddr_d  = cmd_addr;
            arlen_d   = cmd_len;
            arvalid_d = 1'b1;
          end
        end
      end

      S_WADDR: begin
        if (AWREADY) begin
          awvalid_d   = 1'b0;
          wdata_req_d = 1'b1;
          state_d     = S_WDATA;
        end
      end

      // Each beat: wdata_req cycle (capture wdata_in), then WVALID until WREADY.
      S_WDATA: begin
        if (wdata_req) begin
          wvalid_d = 1'b1;
          wdata_d  = wdata_in;
          wlast_d  = (beat_q == len_q);
        end else if (WVALID && WREADY) begin
          wvalid_d = 1'b0;
          wlast_d  = 1'b0;
          beat_d   = beat_q + LEN_W'(1);
          if (WLAST) begin
            bready_d = 1'b1;
            state_d  = S_WRESP;
          end else begin
            wdata_req_d = 1'b1;
          end
        end
      end

      S_WRESP: begin
        if (BVALID) begin
          bready_d    = 1'b0;
          done_resp_d = BRESP;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end else begin
`ifdef AXI4_MASTER_TIMEOUT_EN
          wd_d = wd_q + WD_W'(1);
          if (wd_d == WD_W'(16)) begin
            bready_d    = 1'b0;
            done_resp_d = 2'b11;
            done_d      = 1'b1;
            wd_d        = '0;
            state_d     = S_DONE;
          end
`endif
        end
      end

      S_RADDR: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
      end

      // done_resp accumulates the worst RRESP; RLAST or the final count ends it.
      S_RDATA: begin
        if (RVALID) begin
          rdata_valid_d = 1'b1;
          rdata_out_d   = RDATA;
          beat_d        = beat_q + LEN_W'(1);
          if (RRESP > done_resp) begin
            done_resp_d = RRESP;
          end
          if (RLAST || (beat_q == len_q)) begin
            rready_d = 1'b0;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end
        end else begin
`ifdef AXI4_MASTER_TIMEOUT_EN
          wd_d = wd_q + WD_W'(1);
          if (wd_d == WD_W'(16)) begin
            rready_d    = 1'b0;
            done_resp_d = 2'b11;
            done_d      = 1'b1;
            wd_d        = '0;
            state_d     = S_DONE;
          end
`endif
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      beat_q      <= '0;
      cmd_ready   <= 1'b1;
      wdata_req   <= 1'b0;
      rdata_out   <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      done_resp   <= '0;
      AWADDR      <= '0;
      AWLEN       <= '0;
      AWVALID     <= 1'b0;
      WDATA       <= '0;
      WLAST       <= 1'b0;
      WVALID      <= 1'b0;
      BREADY      <= 1'b0;
      ARADDR      <= '0;
      ARLEN       <= '0;
      ARVALID     <= 1'b0;
      RREADY      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      cmd_ready   <= cmd_ready_d;
      wdata_req   <= wdata_req_d;
      rdata_out   <= rdata_out_d;
      rdata_valid <= rdata_valid_d;
      done        <= done_d;
      done_resp   <= done_resp_d;
      AWADDR      <= awaddr_d;
      AWLEN       <= awlen_d;
      AWVALID     <= awvalid_d;
      WDATA       <= wdata_d;
      WLAST       <= wlast_d;
      WVALID      <= wvalid_d;
      BREADY      <= bready_d;
      ARADDR      <= araddr_d;
      ARLEN       <= arlen_d;
      ARVALID     <= arvalid_d;
      RREADY      <= rready_d;
    end
  end

`ifdef AXI4_MASTER_TIMEOUT_EN
  // Response watchdog counter.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

endmodule

// File: tb/tb_axi4_burst_master.sv
// Scoreboard bench for axi4_burst_master: directed bursts against a small
// AXI slave model; expected AW/AR/W/R/done events are queued when a command
// is issued and popped by a monitor as the DUT presents them.
`timescale 1ns/1ps
module tb_axi4_burst_master;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  logic              ACLK = 1'b0;
  logic              ARESETn = 1'b1;
  logic              cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [7:0]        cmd_len = '0;
  logic [DATA_W-1:0] wdata_in = '0, rdata_out;
  logic              wdata_req, rdata_valid, done;
  logic [1:0]        done_resp;
  logic [ADDR_W-1:0] AWADDR, ARADDR;
  logic [7:0]        AWLEN, ARLEN;
  logic              AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic              ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [DATA_W-1:0] WDATA, RDATA;
  logic [1:0]        BRESP, RRESP;

  axi4_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_in(wdata_in), .wdata_req(wdata_req),
    .rdata_out(rdata_out), .rdata_valid(rdata_valid),
    .done(done), .done_resp(done_resp),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int wl_cyc = 0;
  int done_cyc = 0;

  // Scoreboard queues.
  logic [23:0] exp_aw[$];
  logic [23:0] exp_ar[$];
  logic [32:0] exp_w[$];     // {last, data}
  logic [31:0] exp_r[$];
  logic [1:0]  exp_done[$];
  logic [31:0] src_w[$];     // data handed out on wdata_req
  logic [34:0] rbeats[$];    // slave read beats {last, resp, data}

  // Slave model knobs.
  int          aw_delay = 0;
  bit          wr_toggle = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00;
  bit          b_never = 1'b0;
  bit          spurious = 1'b0;
  bit          aw_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: DUT event with no expected entry", name);
  endtask

  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  // Write data source: answer each wdata_req with the next queued beat.
  initial forever begin
    @(negedge ACLK);
    if (ARESETn && wdata_req) begin
      if (src_w.size() > 0) wdata_in = src_w.pop_front();
      else wdata_in = '0;
    end
  end

  // AXI slave model: capture handshakes mid-cycle, drive just after the edge.
  initial begin : slave
    bit hs_aw, hs_wlast, hs_b, hs_ar, hs_r, r_act, spur_q;
    int aw_cnt;
    logic [34:0] beat;
    r_act = 0; spur_q = 0; aw_cnt = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0;
    RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0;
    forever begin
      @(negedge ACLK);
      hs_aw    = AWVALID && AWREADY;
      hs_wlast = WVALID && WREADY && WLAST;
      hs_b     = BVALID && BREADY;
      hs_ar    = ARVALID && ARREADY;
      hs_r     = RVALID && RREADY;
      @(posedge ACLK);
      #1;
      if (!ARESETn) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0; RLAST = 0;
        aw_cnt = 0; r_act = 0;
        continue;
      end
      if (AWVALID && !hs_aw) begin
        AWREADY = (aw_cnt >= aw_delay);
        aw_cnt++;
      end else begin
        AWREADY = 0;
        aw_cnt = 0;
      end
      WREADY = wr_toggle ? ~WREADY : 1'b1;
      if (hs_b) BVALID = 0;
      if (hs_wlast && !b_never) begin
        BVALID = 1;
        BRESP  = bresp_cfg;
      end
      ARREADY = ARVALID && !hs_ar;
      if (hs_r) RVALID = 0;
      if (hs_ar) r_act = 1;
      if (r_act && !RVALID) begin
        if (rbeats.size() > 0) begin
          beat = rbeats.pop_front();
          {RLAST, RRESP, RDATA} = beat;
          RVALID = 1;
        end else begin
          r_act = 0;
        end
      end
      if (spurious) begin
        BVALID = 1; RVALID = 1; RLAST = 1; RDATA = 32'hBAD0_BAD0;
      end else if (spur_q) begin
        BVALID = 0; RVALID = 0; RLAST = 0;
      end
      spur_q = spurious;
    end
  end

  // Monitor: pops expectations as events appear, checks stall stability.
  initial begin : monitor
    logic p_aw, p_w, p_ar, p_wlast;
    logic [ADDR_W-1:0] p_awaddr, p_araddr;
    logic [7:0] p_awlen, p_arlen;
    logic [DATA_W-1:0] p_wdata;
    p_aw = 0; p_w = 0; p_ar = 0; p_wlast = 0;
    p_awaddr = '0; p_araddr = '0; p_awlen = '0; p_arlen = '0; p_wdata = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        p_aw = 0; p_w = 0; p_ar = 0; aw_seen = 0;
        continue;
      end
      if (p_aw) begin
        chk("aw_hold_valid", AWVALID, 1);
        chk("aw_hold_addr", {AWADDR, AWLEN}, {p_awaddr, p_awlen});
      end
      if (p_w) begin
        chk("w_hold_valid", WVALID, 1);
        chk("w_hold_data", {WLAST, WDATA}, {p_wlast, p_wdata});
      end
      if (p_ar) begin
        chk("ar_hold_valid", ARVALID, 1);
        chk("ar_hold_addr", {ARADDR, ARLEN}, {p_araddr, p_arlen});
      end
      if (WVALID) chk("w_after_aw", aw_seen, 1);
      if (AWVALID && AWREADY) begin
        if (exp_aw.size() == 0) unexpected("aw");
        else chk("aw_addr_len", {AWADDR, AWLEN}, exp_aw.pop_front());
        aw_seen = 1;
      end
      if (ARVALID && ARREADY) begin
        if (exp_ar.size() == 0) unexpected("ar");
        else chk("ar_addr_len", {ARADDR, ARLEN}, exp_ar.pop_front());
      end
      if (WVALID && WREADY) begin
        if (exp_w.size() == 0) unexpected("w");
        else chk("w_last_data", {WLAST, WDATA}, exp_w.pop_front());
        if (WLAST) wl_cyc = cyc;
      end
      if (rdata_valid) begin
        if (exp_r.size() == 0) unexpected("rdata");
        else chk("rdata", rdata_out, exp_r.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        aw_seen = 0;
        if (exp_done.size() == 0) unexpected("done");
        else chk("done_resp", done_resp, exp_done.pop_front());
      end
      p_aw = AWVALID && !AWREADY; p_awaddr = AWADDR; p_awlen = AWLEN;
      p_w  = WVALID && !WREADY;   p_wdata  = WDATA;  p_wlast = WLAST;
      p_ar = ARVALID && !ARREADY; p_araddr = ARADDR; p_arlen = ARLEN;
    end
  end

  task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [7:0] l);
    int n;
    n = 0;
    @(posedge ACLK); #1;
    while (!cmd_ready && n < 100) begin
      @(posedge ACLK); #1;
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    @(posedge ACLK); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_done(input int start);
    for (int i = 0; i < 300 && done_cnt == start; i++) @(posedge ACLK);
    chk("done_seen", done_cnt != start, 1);
    @(posedge ACLK); #1;
  endtask

  task automatic push_write(input logic [ADDR_W-1:0] a, input logic [7:0] l,
                            input logic [31:0] base, input logic [1:0] resp);
    exp_aw.push_back({a, l});
    for (int i = 0; i <= int'(l); i++) begin
      src_w.push_back(base + 32'(i));
      exp_w.push_back({(i == int'(l)), base + 32'(i)});
    end
    exp_done.push_back(resp);
  endtask

  initial begin : main
    int start;
    #1 ARESETn = 0;
    #2;
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_wvalid", WVALID, 0);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_bready_rready", {BREADY, RREADY}, 0);
    chk("rst_pulses", {wdata_req, rdata_valid, done}, 0);
    chk("rst_regs", {AWADDR, WDATA, done_resp}, 0);
    repeat (3) @(posedge ACLK);
    #1 ARESETn = 1;
    @(posedge ACLK); #1;
    chk("rst_cmd_ready", cmd_ready, 1);

    // Write 0x0040 len 3, all ready, OKAY.
    push_write(16'h0040, 8'd3, 32'hA000_0000, 2'b00);
    start = done_cnt;
    issue(1, 16'h0040, 8'd3);
    wait_done(start);

    // Single-beat read of 0xDEADBEEF.
    exp_ar.push_back({16'h0100, 8'd0});
    rbeats.push_back({1'b1, 2'b00, 32'hDEAD_BEEF});
    exp_r.push_back(32'hDEAD_BEEF);
    exp_done.push_back(2'b00);
    start = done_cnt;
    issue(0, 16'h0100, 8'd0);
    wait_done(start);

    // AW stalled 5 cycles, WREADY toggling, EXOKAY response.
    aw_delay = 5; wr_toggle = 1; bresp_cfg = 2'b01;
    push_write(16'h1230, 8'd2, 32'h5500_0000, 2'b01);
    start = done_cnt;
    issue(1, 16'h1230, 8'd2);
    wait_done(start);
    aw_delay = 0; wr_toggle = 0; bresp_cfg = 2'b00;

    // Read len 2, RRESP 00,10,00 -> worst is 10.
    exp_ar.push_back({16'h0200, 8'd2});
    rbeats.push_back({1'b0, 2'b00, 32'h1111_0000});
    rbeats.push_back({1'b0, 2'b10, 32'h1111_0001});
    rbeats.push_back({1'b1, 2'b00, 32'h1111_0002});
    exp_r.push_back(32'h1111_0000); exp_r.push_back(32'h1111_0001); exp_r.push_back(32'h1111_0002);
    exp_done.push_back(2'b10);
    start = done_cnt;
    issue(0, 16'h0200, 8'd2);
    wait_done(start);

    // Early RLAST: len 3 but RLAST on beat 2.
    exp_ar.push_back({16'h0300, 8'd3});
    rbeats.push_back({1'b0, 2'b01, 32'h2222_0000});
    rbeats.push_back({1'b1, 2'b00, 32'h2222_0001});
    exp_r.push_back(32'h2222_0000); exp_r.push_back(32'h2222_0001);
    exp_done.push_back(2'b01);
    start = done_cnt;
    issue(0, 16'h0300, 8'd3);
    wait_done(start);

    // No RLAST: beat count ends a len-1 read after two beats.
    exp_ar.push_back({16'h0400, 8'd1});
    rbeats.push_back({1'b0, 2'b00, 32'h3333_0000});
    rbeats.push_back({1'b0, 2'b11, 32'h3333_0001});
    exp_r.push_back(32'h3333_0000); exp_r.push_back(32'h3333_0001);
    exp_done.push_back(2'b11);
    start = done_cnt;
    issue(0, 16'h0400, 8'd1);
    wait_done(start);

    // Stray BVALID/RVALID while idle must be ignored.
    start = done_cnt;
    spurious = 1;
    repeat (5) begin
      @(posedge ACLK); #1;
      chk("spurious_idle", cmd_ready, 1);
    end
    spurious = 0;
    repeat (2) @(posedge ACLK);
    #1 chk("spurious_no_done", done_cnt, start);

    // Single-beat write, SLVERR.
    bresp_cfg = 2'b10;
    push_write(16'h00FC, 8'd0, 32'h7777_0000, 2'b10);
    start = done_cnt;
    issue(1, 16'h00FC, 8'd0);
    wait_done(start);
    bresp_cfg = 2'b00;

    // Reset in the middle of a read that never gets data.
    exp_ar.push_back({16'h0500, 8'd2});
    start = done_cnt;
    issue(0, 16'h0500, 8'd2);
    for (int i = 0; i < 50 && !RREADY; i++) begin
      @(posedge ACLK); #1;
    end
    chk("mid_rready", RREADY, 1);
    #2 ARESETn = 0;
    #1;
    chk("mid_rst_valids", {AWVALID, WVALID, ARVALID}, 0);
    chk("mid_rst_readys", {BREADY, RREADY}, 0);
    chk("mid_rst_pulses", {wdata_req, rdata_valid, done}, 0);
    exp_r.delete(); exp_done.delete(); rbeats.delete(); src_w.delete(); exp_w.delete();
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1;
    repeat (10) @(posedge ACLK);
    #1;
    chk("mid_rst_no_done", done_cnt, start);
    chk("mid_rst_cmd_ready", cmd_ready, 1);

    // Recovery after reset.
    push_write(16'h0008, 8'd0, 32'h9999_0000, 2'b00);
    start = done_cnt;
    issue(1, 16'h0008, 8'd0);
    wait_done(start);

`ifdef AXI4_MASTER_TIMEOUT_EN
    // Missing B response: watchdog fires 16 edges after the WLAST handshake.
    b_never = 1;
    push_write(16'h0010, 8'd0, 32'hCCCC_0000, 2'b11);
    exp_done.delete(exp_done.size() - 1);
    exp_done.push_back(2'b11);
    start = done_cnt;
    issue(1, 16'h0010, 8'd0);
    wait_done(start);
    chk("timeout_latency", done_cyc - wl_cyc - 1, 16);
    b_never = 0;
`endif

    repeat (3) @(posedge ACLK);
    chk("left_aw", exp_aw.size(), 0);
    chk("left_ar", exp_ar.size(), 0);
    chk("left_w", exp_w.size(), 0);
    chk("left_r", exp_r.size(), 0);
    chk("left_done", exp_done.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/axi4_burst_master.md
AXI4_BURST_MASTER -- requirements
Module: axi4_burst_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, AXI address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, AXI data width in bits; every beat is full-width INCR with all byte lanes enabled.
REQ-003 ACLK  in  1  single clock; all logic on rising edge.
REQ-004 ARESETn  in  1  reset, asynchronous assert, active-low.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  block idle, accepts command.
REQ-007 cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-008 cmd_addr  in  ADDR_W  burst start address.
REQ-009 cmd_len  in  8  beats minus one (AXI LEN encoding).
REQ-010 wdata_in  in  DATA_W  next write beat, sampled on the cycle wdata_req is high.
REQ-011 wdata_req  out  1  one-cycle pulse: user supplies the next beat on wdata_in.
REQ-012 rdata_out  out  DATA_W  read beat.
REQ-013 rdata_valid  out  1  one-cycle pulse, rdata_out valid.
REQ-014 done  out  1  one-cycle pulse, burst complete.
REQ-015 done_resp  out  2  BRESP, or worst RRESP of the burst, qualified by done.
REQ-016 AWADDR / AWLEN  out  ADDR_W / 8  write address and length.
REQ-017 AWVALID out 1, AWREADY in 1  write address handshake.
REQ-018 WDATA out DATA_W, WLAST out 1  write data and last-beat flag.
REQ-019 WVALID out 1, WREADY in 1  write data handshake.
REQ-020 BRESP in 2, BVALID in 1, BREADY out 1  write response channel.
REQ-021 ARADDR / ARLEN  out  ADDR_W / 8  read address and length.
REQ-022 ARVALID out 1, ARREADY in 1  read address handshake.
REQ-023 RDATA in DATA_W, RRESP in 2, RLAST in 1  read data channel.
REQ-024 RVALID in 1, RREADY out 1  read data handshake.

Function
REQ-025 SHALL implement the FSM IDLE -> (WADDR -> WDATA -> WRESP | RADDR -> RDATA) -> DONE -> IDLE; cmd_ready=1 only in IDLE; a command is taken on cmd_valid&&cmd_ready and its fields are registered.
REQ-026 AWVALID/ARVALID SHALL assert the cycle after acceptance, hold with stable address and length until the READY handshake, then deassert the next cycle.
REQ-027 WDATA phase SHALL start only after the AW handshake; wdata_req pulses one cycle before each beat is presented; WVALID SHALL hold with stable WDATA/WLAST until WREADY; WLAST=1 exactly on beat cmd_len+1.
REQ-028 A beat counter (8-bit) SHALL count handshakes; the last-beat index equals cmd_len, and cmd_len=0 yields a single beat with WLAST=1.
REQ-029 BREADY SHALL be 1 only in WRESP; a B handshake moves to DONE with done_resp=BRESP.
REQ-030 RREADY SHALL be 1 throughout RDATA; each R handshake pulses rdata_valid with rdata_out=RDATA the next cycle; done_resp takes the maximum RRESP seen; RLAST or the beat count reaching cmd_len+1 moves to DONE, whichever comes first.
REQ-031 DONE SHALL last exactly one cycle with done=1; the next command can be accepted at the earliest the following cycle.
REQ-032 Responses (BVALID/RVALID) arriving outside WRESP/RDATA SHALL be ignored and SHALL NOT change state.

Reset
REQ-033 ARESETn low SHALL immediately force IDLE, with all VALID/READY outputs, wdata_req, rdata_valid and done at 0, cmd_ready at 1 on release, and counters, addresses, WDATA and done_resp at 0; a burst in flight is abandoned with no done pulse.

Configuration
REQ-034 With AXI4_MASTER_TIMEOUT_EN defined, a 5-bit watchdog SHALL count cycles waiting in WRESP or RDATA without a handshake; at 16 the FSM goes to DONE with done_resp=2'b11. Without the macro, the FSM waits indefinitely and no watchdog logic exists.

Verification
REQ-035 Write addr 0x0040, len 3, AWREADY=1, WREADY=1, BRESP=00 -> four W beats, WLAST on the fourth only, done=1 with done_resp=00.
REQ-036 Read addr 0x0100, len 0, RDATA=0xDEADBEEF, RLAST=1 -> one rdata_valid with 0xDEADBEEF, then done; ARLEN=0.
REQ-037 Write with AWREADY held low 5 cycles and WREADY toggling -> AWVALID, AWADDR, WVALID and WDATA stay stable until each handshake, and no W beat is sent before the AW handshake.
REQ-038 Read len 2 with RRESP=00,10,00 -> done_resp=10; reset asserted mid-burst -> all VALID/READY outputs are 0 immediately and no done pulse occurs.
REQ-039 AXI4_MASTER_TIMEOUT_EN defined, BVALID never asserted -> done 16 cycles after the WLAST handshake with done_resp=11.
